// File: rtl/cursor_blink_writer.sv
// Blinks the paint cursor on the LED framebuffer. Each timer tick alternately draws the
// cursor in white or restores the saved pixel that was underneath it.
module cursor_blink_writer #(
  parameter int                 X_W          = 6,
  parameter int                 Y_W          = 6,
  parameter int                 COLOR_W      = 24,
  parameter logic [COLOR_W-1:0] CURSOR_COLOR = 24'hFFFFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init,
  input  logic                 cb_tick,
  input  logic [X_W-1:0]       cursor_x,
  input  logic [Y_W-1:0]       cursor_y,
  output logic                 rd_req,
  output logic [X_W+Y_W-1:0]   rd_addr,
  input  logic [COLOR_W-1:0]   rd_data,
  input  logic                 rd_valid,
  output logic                 wr_en,
  output logic [X_W+Y_W-1:0]   wr_addr,
  output logic [COLOR_W-1:0]   wr_data,
  input  logic                 wr_ack,
  output logic                 visible,
  output logic                 busy
);

  localparam int AW = X_W + Y_W;

  typedef enum logic [2:0] {
    IDLE,
    SAVE,
    DRAW,
    SHOWN,
    RESTORE,
    HIDDEN
  } state_t;

  // Why the cursor is being erased; decides where RESTORE goes once the write lands.
  typedef enum logic [1:0] {
    CAUSE_OFF,
    CAUSE_MOVE,
    CAUSE_TICK
  } cause_t;

  state_t             state;
  cause_t             cause;
  logic               tick_pend;
  logic [AW-1:0]      saved_addr;
  logic [COLOR_W-1:0] saved_pixel;

  logic [AW-1:0]      cur_pos;
  logic               moved;
  logic               tick_seen;

  assign cur_pos   = {cursor_y, cursor_x};
  assign moved     = (cur_pos != saved_addr);
  assign tick_seen = cb_tick | tick_pend;

  // NOTE: every state bit and output is assigned with <= so all outputs are true registers
  // and the reset branch clears them asynchronously without any combinational path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cause       <= CAUSE_OFF;
      tick_pend   <= 1'b0;
      saved_addr  <= '0;
      saved_pixel <= '0;
      rd_req      <= 1'b0;
      rd_addr     <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      visible     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tick_pend <= 1'b0;
          if (init) begin
            state      <= SAVE;
            saved_addr <= cur_pos;
            rd_addr    <= cur_pos;
            rd_req     <= 1'b1;
            busy       <= 1'b1;
          end
        end

        SAVE: begin
          if (cb_tick) tick_pend <= 1'b1;
          if (rd_valid) begin
            rd_req      <= 1'b0;
            saved_pixel <= rd_data;
            if (init) begin
              state   <= DRAW;
              wr_en   <= 1'b1;
              wr_addr <= saved_addr;
              wr_data <= CURSOR_COLOR;
            end else begin
              // Nothing was drawn yet, so there is nothing to undo.
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        DRAW: begin
          if (cb_tick) tick_pend <= 1'b1;
          if (wr_ack) begin
            state   <= SHOWN;
            wr_en   <= 1'b0;
            visible <= 1'b1;
            busy    <= 1'b0;
          end
        end

        SHOWN: begin
          if (!init || moved || tick_seen) begin
            state   <= RESTORE;
            busy    <= 1'b1;
            wr_en   <= 1'b1;
            wr_addr <= saved_addr;
            wr_data <= saved_pixel;
          end
          if (!init) begin
            cause <= CAUSE_OFF;
          end else if (moved) begin
            // A tick coinciding with a move is kept for the next blink decision.
            cause <= CAUSE_MOVE;
            if (cb_tick) tick_pend <= 1'b1;
          end else if (tick_seen) begin
            cause     <= CAUSE_TICK;
            tick_pend <= 1'b0;
          end
        end

        RESTORE: begin
          if (cb_tick) tick_pend <= 1'b1;
          if (wr_ack) begin
            wr_en   <= 1'b0;
            visible <= 1'b0;
            case (cause)
              CAUSE_MOVE: begin
                state      <= SAVE;
                saved_addr <= cur_pos;
                rd_addr    <= cur_pos;
                rd_req     <= 1'b1;
              end
              CAUSE_TICK: begin
                state <= HIDDEN;
                busy  <= 1'b0;
              end
              default: begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            endcase
          end
        end

        HIDDEN: begin
          if (!init) begin
            state <= IDLE;
          end else if (tick_seen) begin
            state      <= SAVE;
            tick_pend  <= 1'b0;
            saved_addr <= cur_pos;
            rd_addr    <= cur_pos;
            rd_req     <= 1'b1;
            busy       <= 1'b1;
          end
        end

        default: begin
          state   <= IDLE;
          rd_req  <= 1'b0;
          wr_en   <= 1'b0;
          visible <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cursor_blink_writer.sv
// Bench for cursor_blink_writer: framebuffer responder, transaction-level reference model,
// directed scenarios with literal expectations, then a randomized run.
`timescale 1ns/1ps
module tb_cursor_blink_writer;

  localparam int          X_W     = 6;
  localparam int          Y_W     = 6;
  localparam int          COLOR_W = 24;
  localparam int          AW      = 12;
  localparam logic [23:0] WHITE   = 24'hFFFFFF;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              init = 1'b0;
  logic              cb_tick = 1'b0;
  logic [X_W-1:0]    cursor_x = '0;
  logic [Y_W-1:0]    cursor_y = '0;
  logic              rd_req;
  logic [AW-1:0]     rd_addr;
  logic [COLOR_W-1:0] rd_data = '0;
  logic              rd_valid = 1'b0;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [COLOR_W-1:0] wr_data;
  logic              wr_ack = 1'b0;
  logic              visible;
  logic              busy;

  cursor_blink_writer #(
    .X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W), .CURSOR_COLOR(WHITE)
  ) dut (
    .clk(clk), .rst(rst), .init(init), .cb_tick(cb_tick),
    .cursor_x(cursor_x), .cursor_y(cursor_y),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .visible(visible), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- framebuffer responder ----------------
  logic [23:0] fb      [0:4095];
  logic [23:0] fb_snap [0:4095];
  int rd_lat_fix = 0, wr_lat_fix = 0;
  bit noise = 1'b0;
  int rd_cnt = 0, wr_cnt = 0, rd_lat_cur = 0, wr_lat_cur = 0;

  always @(negedge clk) begin
    if (rst) begin
      rd_valid = 1'b0;
      wr_ack   = 1'b0;
      rd_cnt   = 0;
      wr_cnt   = 0;
    end else begin
      if (rd_req) begin
        if (rd_cnt == 0) rd_lat_cur = (rd_lat_fix >= 0) ? rd_lat_fix : int'($urandom_range(0, 3));
        if (rd_cnt >= rd_lat_cur) begin
          rd_valid = 1'b1;
          rd_data  = fb[rd_addr];
          rd_cnt   = 0;
        end else begin
          rd_valid = 1'b0;
          rd_data  = 24'($urandom);
          rd_cnt++;
        end
      end else begin
        rd_cnt   = 0;
        rd_valid = noise && ($urandom_range(0, 3) == 0);
        rd_data  = 24'($urandom);
      end
      if (wr_en) begin
        if (wr_cnt == 0) wr_lat_cur = (wr_lat_fix >= 0) ? wr_lat_fix : int'($urandom_range(0, 3));
        if (wr_cnt >= wr_lat_cur) begin
          wr_ack      = 1'b1;
          fb[wr_addr] = wr_data;
          wr_cnt      = 0;
        end else begin
          wr_ack = 1'b0;
          wr_cnt++;
        end
      end else begin
        wr_cnt = 0;
        wr_ack = noise && ($urandom_range(0, 3) == 0);
      end
    end
  end

  // ---------------- reference model ----------------
  // Described as: is the block enabled, which bus operation is outstanding, and whether the
  // cursor pixel currently sits in the framebuffer.
  typedef enum {OP_NONE, OP_READ, OP_WRITE} op_t;
  typedef enum {WHY_OFF, WHY_MOVE, WHY_TICK} why_t;

  bit          m_active, m_drawn, m_pend;
  op_t         m_op;
  why_t        m_why;
  logic [11:0] m_addr;
  logic [23:0] m_pix;

  always @(posedge clk or posedge rst) begin : model
    logic [11:0] pos;
    if (rst) begin
      m_active = 1'b0; m_drawn = 1'b0; m_pend = 1'b0;
      m_op = OP_NONE; m_why = WHY_OFF; m_addr = '0; m_pix = '0;
    end else begin
      pos = {cursor_y, cursor_x};
      if (!m_active) begin
        m_pend = 1'b0;
        if (init) begin m_active = 1'b1; m_op = OP_READ; m_addr = pos; end
      end else if (m_op == OP_READ) begin
        if (cb_tick) m_pend = 1'b1;
        if (rd_valid) begin
          m_pix = rd_data;
          if (init) m_op = OP_WRITE;
          else begin m_op = OP_NONE; m_active = 1'b0; end
        end
      end else if (m_op == OP_WRITE) begin
        if (cb_tick) m_pend = 1'b1;
        if (wr_ack) begin
          m_op = OP_NONE;
          if (!m_drawn) m_drawn = 1'b1;
          else begin
            m_drawn = 1'b0;
            if (m_why == WHY_OFF) m_active = 1'b0;
            else if (m_why == WHY_MOVE) begin m_op = OP_READ; m_addr = pos; end
          end
        end
      end else if (m_drawn) begin
        if (!init) begin m_why = WHY_OFF; m_op = OP_WRITE; end
        else if (pos != m_addr) begin
          m_why = WHY_MOVE; m_op = OP_WRITE;
          if (cb_tick) m_pend = 1'b1;
        end else if (cb_tick || m_pend) begin
          m_why = WHY_TICK; m_op = OP_WRITE; m_pend = 1'b0;
        end
      end else begin
        if (!init) m_active = 1'b0;
        else if (cb_tick || m_pend) begin m_op = OP_READ; m_addr = pos; m_pend = 1'b0; end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      check("rd_req", rd_req, m_op == OP_READ);
      check("wr_en", wr_en, m_op == OP_WRITE);
      check("visible", visible, m_drawn);
      check("busy", busy, m_active && (m_op != OP_NONE));
      if (m_op == OP_READ) check("rd_addr", rd_addr, m_addr);
      if (m_op == OP_WRITE) begin
        check("wr_addr", wr_addr, m_addr);
        check("wr_data", wr_data, m_drawn ? m_pix : WHITE);
      end
    end
  end

  // ---------------- directed and random stimulus ----------------
  function automatic logic dut_bit(input int which);
    case (which)
      0:       return rd_req;
      1:       return wr_en;
      2:       return visible;
      default: return busy;
    endcase
  endfunction

  task automatic wait_sig(input string name, input int which, input logic val, input int budget);
    int n;
    n = 0;
    while (dut_bit(which) !== val && n < budget) begin
      step(1);
      n++;
    end
    if (dut_bit(which) !== val) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout %s: still %0b after %0d cycles, expected %0b", name, dut_bit(which), n, val);
    end
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int wr_rises, rd_seen, diffs;
    logic prev_wr;

    for (int i = 0; i < 4096; i++) fb[i] = 24'($urandom);
    fb[12'h0C5] = 24'h00FF00;
    fb[12'h0C6] = 24'h123456;
    fb[12'h0C7] = 24'hABCDEF;

    // Reset state.
    step(2);
    check("reset rd_req", rd_req, 1'b0);
    check("reset wr_en", wr_en, 1'b0);
    check("reset visible", visible, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset rd_addr", rd_addr, 12'h000);
    check("reset wr_addr", wr_addr, 12'h000);
    check("reset wr_data", wr_data, 24'h000000);
    rst = 1'b0;
    step(2);
    check("idle busy", busy, 1'b0);

    // First draw at (5,3).
    rd_lat_fix = 2; wr_lat_fix = 1;
    cursor_x = 6'd5; cursor_y = 6'd3; init = 1'b1;
    wait_sig("first read", 0, 1'b1, 5);
    check("first rd_addr", rd_addr, 12'h0C5);
    check("first busy", busy, 1'b1);
    step(2);
    check("rd_req held", rd_req, 1'b1);
    wait_sig("first draw", 1, 1'b1, 10);
    check("draw wr_addr", wr_addr, 12'h0C5);
    check("draw wr_data", wr_data, 24'hFFFFFF);
    wait_sig("first visible", 2, 1'b1, 10);
    check("shown busy", busy, 1'b0);
    check("shown wr_en", wr_en, 1'b0);
    check("fb white 0C5", fb[12'h0C5], 24'hFFFFFF);

    // Tick hides, second tick redraws.
    step(3);
    check("shown steady", visible, 1'b1);
    cb_tick = 1'b1; step(1); cb_tick = 1'b0;
    wait_sig("hide write", 1, 1'b1, 5);
    check("hide wr_addr", wr_addr, 12'h0C5);
    check("hide wr_data", wr_data, 24'h00FF00);
    wait_sig("hidden", 2, 1'b0, 10);
    check("hidden busy", busy, 1'b0);
    check("fb restored 0C5", fb[12'h0C5], 24'h00FF00);
    step(4);
    check("hidden waits", rd_req, 1'b0);
    cb_tick = 1'b1; step(1); cb_tick = 1'b0;
    wait_sig("redraw read", 0, 1'b1, 5);
    check("redraw rd_addr", rd_addr, 12'h0C5);
    wait_sig("redraw shown", 2, 1'b1, 20);

    // Move to (6,3) without a tick.
    cursor_x = 6'd6;
    wait_sig("move restore", 1, 1'b1, 5);
    check("move restore addr", wr_addr, 12'h0C5);
    check("move restore data", wr_data, 24'h00FF00);
    wait_sig("move read", 0, 1'b1, 10);
    check("move rd_addr", rd_addr, 12'h0C6);
    wait_sig("move draw", 1, 1'b1, 10);
    check("move draw addr", wr_addr, 12'h0C6);
    check("move draw data", wr_data, 24'hFFFFFF);
    wait_sig("move shown", 2, 1'b1, 10);
    check("fb 0C5 after move", fb[12'h0C5], 24'h00FF00);

    // Tick during a slow draw at (7,3) is held and consumed right after SHOWN.
    wr_lat_fix = 4; cursor_x = 6'd7;
    wait_sig("slow restore", 1, 1'b1, 5);
    wait_sig("slow read", 0, 1'b1, 20);
    wait_sig("slow draw", 1, 1'b1, 20);
    check("slow draw addr", wr_addr, 12'h0C7);
    cb_tick = 1'b1; step(1); cb_tick = 1'b0;
    wait_sig("slow shown", 2, 1'b1, 10);
    check("shown one cycle wr_en", wr_en, 1'b0);
    step(1);
    check("pending tick restore", wr_en, 1'b1);
    check("pending restore addr", wr_addr, 12'h0C7);
    check("pending restore data", wr_data, 24'hABCDEF);
    wait_sig("pending hidden", 2, 1'b0, 10);
    step(5);
    check("tick consumed", rd_req, 1'b0);

    // init drop with tick and move on the same SHOWN cycle.
    wr_lat_fix = 1;
    cb_tick = 1'b1; step(1); cb_tick = 1'b0;
    wait_sig("pre-off shown", 2, 1'b1, 20);
    init = 1'b0; cb_tick = 1'b1; cursor_x = 6'd8;
    wr_rises = 0; rd_seen = 0; prev_wr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (i == 1) cb_tick = 1'b0;
      if (wr_en && !prev_wr) wr_rises++;
      prev_wr = wr_en;
      if (rd_req) rd_seen++;
    end
    check("off restore count", wr_rises, 1);
    check("off no read", rd_seen, 0);
    check("off visible", visible, 1'b0);
    check("off busy", busy, 1'b0);
    check("fb 0C7 after off", fb[12'h0C7], 24'hABCDEF);

    // Re-enable: no stale tick may survive IDLE.
    init = 1'b1;
    wait_sig("reinit read", 0, 1'b1, 5);
    check("reinit rd_addr", rd_addr, 12'h0C8);
    wait_sig("reinit shown", 2, 1'b1, 20);
    step(6);
    check("no stale tick", wr_en, 1'b0);
    init = 1'b0;
    wait_sig("directed end", 2, 1'b0, 20);
    step(3);
    for (int i = 0; i < 4096; i++) fb_snap[i] = fb[i];

    // Randomized run.
    noise = 1'b1; rd_lat_fix = -1; wr_lat_fix = -1; init = 1'b1;
    repeat (3000) begin
      step(1);
      cb_tick = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 24) == 0) cursor_x = 6'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) cursor_y = 6'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) init = ~init;
    end
    init = 1'b0; cb_tick = 1'b0;
    for (int i = 0; i < 200 && (busy || visible); i++) step(1);
    step(3);
    check("random end idle", busy | visible, 1'b0);
    diffs = 0;
    for (int i = 0; i < 4096; i++) if (fb[i] !== fb_snap[i]) diffs++;
    check("framebuffer clean", diffs, 0);

    // Asynchronous reset during a restore write.
    noise = 1'b0; rd_lat_fix = 1; wr_lat_fix = 1;
    cursor_x = 6'd5; cursor_y = 6'd3; init = 1'b1;
    wait_sig("pre-reset shown", 2, 1'b1, 30);
    wr_lat_fix = 20;
    cb_tick = 1'b1; step(1); cb_tick = 1'b0;
    check("pre-reset wr_en", wr_en, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async rd_req", rd_req, 1'b0);
    check("async wr_en", wr_en, 1'b0);
    check("async visible", visible, 1'b0);
    check("async busy", busy, 1'b0);
    @(negedge clk);
    init = 1'b0; rst = 1'b0;
    step(3);
    check("post-reset rd_req", rd_req, 1'b0);
    check("post-reset busy", busy, 1'b0);
    check("post-reset visible", visible, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cursor_blink_writer.md
Name: cursor_blink_writer

Overview:
- Downstream consumer of the white-count timer's CB done pulse (5,000,000-cycle period).
- Blinks the paint cursor on the LED framebuffer: on each tick it alternately draws the cursor in white, then restores the pixel that was underneath.
- Saves the underlying pixel through the framebuffer read port before every draw, and restores it on hide or when the cursor moves.
- Sits between the timer and the framebuffer arbiter inside PAINT_ASM.

Parameters:
- X_W, 6, cursor column width (64 columns).
- Y_W, 6, cursor row width (64 rows).
- COLOR_W, 24, pixel colour width.
- CURSOR_COLOR, 24'hFFFFFF, colour drawn while the cursor is visible (white).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- init  in  1  level enable; blinking runs while high.
- cb_tick  in  1  single-cycle done pulse from the white-count timer.
- cursor_x  in  X_W  current cursor column.
- cursor_y  in  Y_W  current cursor row.
- rd_req  out  1  framebuffer read request.
- rd_addr  out  X_W+Y_W  read address, {y,x}.
- rd_data  in  COLOR_W  read data, valid with rd_valid.
- rd_valid  in  1  read completion strobe.
- wr_en  out  1  framebuffer write request.
- wr_addr  out  X_W+Y_W  write address, {y,x}.
- wr_data  out  COLOR_W  write data.
- wr_ack  in  1  write completion strobe.
- visible  out  1  high while the cursor pixel is present in the framebuffer.
- busy  out  1  high in any state other than IDLE, SHOWN or HIDDEN.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - rd_req=0, wr_en=0, visible=0, busy=0.
  - rd_addr, wr_addr, wr_data, saved pixel and saved address = 0.
  - tick_pend=0.
- Registered outputs: all outputs are registered. Address and data are stable the whole time the matching request is high.
- Read handshake:
  - rd_req rises with rd_addr and is held until a cycle where rd_valid=1.
  - rd_data is captured into the saved-pixel register on that cycle.
  - rd_req=0 from the next cycle.
  - rd_valid while rd_req=0 is ignored.
- Write handshake:
  - wr_en is held with stable wr_addr/wr_data until wr_ack=1.
  - wr_en is deasserted the next cycle.
  - wr_ack while wr_en=0 is ignored.
- FSM states and transitions:
  - IDLE: init=1 goes to SAVE. tick_pend is cleared in IDLE.
  - SAVE: latch saved_addr={cursor_y,cursor_x}; issue read; on rd_valid go to DRAW.
  - DRAW: write CURSOR_COLOR at saved_addr; on wr_ack set visible=1 and go to SHOWN.
  - SHOWN:
    - go to RESTORE if (tick or tick_pend), or cursor position != saved_addr, or init=0.
    - RESTORE's exit is chosen by the cause, priority init=0 > move > tick.
  - RESTORE: write the saved pixel at saved_addr; on wr_ack set visible=0, then:
    - init=0 → IDLE;
    - move → SAVE (immediate redraw at the new position, no tick needed);
    - tick → HIDDEN.
  - HIDDEN: tick or tick_pend goes to SAVE; init=0 goes to IDLE.
- Tick handling:
  - cb_tick arriving in SAVE, DRAW or RESTORE sets tick_pend.
  - tick_pend is consumed (cleared) when SHOWN or HIDDEN acts on it.
  - At most one tick is pending; extra ticks are dropped.
- Cursor movement:
  - The position is sampled only on SAVE entry and in SHOWN.
  - Movement during HIDDEN needs no framebuffer action; the new position is picked up at the next SAVE.
- init deassert:
  - During SAVE or DRAW: the in-flight handshake completes first.
  - If the draw completed, RESTORE runs before IDLE.
  - If the draw had not started, go straight to IDLE.
  - The framebuffer is never left with the cursor drawn after the block returns to IDLE.
- Simultaneous events in SHOWN: init=0 beats move, move beats tick. If a tick occurs with a move, it is kept as tick_pend.
- Reset mid-handshake: requests drop immediately. The framebuffer content is not repaired; the owner re-clears it.
- Address packing: {y,x}, width X_W+Y_W, no wrap arithmetic performed.

Test Plan:
- Reset, init=1, cursor (5,3), rd_valid after 2 cycles with rd_data=24'h00FF00 → rd_addr=12'h0C5; then wr_en with wr_data=24'hFFFFFF, wr_addr=12'h0C5; visible=1 after wr_ack.
- In SHOWN, pulse cb_tick → write 24'h00FF00 to 12'h0C5, visible=0, state HIDDEN; second cb_tick → new read/draw cycle.
- In SHOWN, move cursor to (6,3) with no tick → restore 24'h00FF00 at 12'h0C5, then read 12'h0C6 and draw white there; visible=1 with no tick required.
- cb_tick during DRAW with wr_ack held off 4 cycles → after wr_ack, SHOWN is left on the next cycle (pending tick consumed) and the pixel is restored.
- init=0 while SHOWN, with cb_tick and a move on the same cycle → exactly one restore write, then IDLE; no further rd_req; tick_pend=0.
- Assert rst while wr_en=1 → rd_req, wr_en, visible and busy are all 0 in the same cycle (asynchronous); after release, state IDLE.
